// File: rtl/fpu_div_sequencer_pkg.sv
// Shared types and helpers for the fpuDivider issue/retire sequencer.
// Holds the sequencer state encoding, default geometry and the width
// helpers used to size FIFO pointers and the occupancy counter.
package fpu_div_sequencer_pkg;

    // state      | meaning
    // SEQ_IDLE   | no operation in flight, waiting for a queued pair
    // SEQ_ISSUE  | divStart pulsed this cycle with the FIFO head on divIn1/divIn2
    // SEQ_BUSY   | divider working, waiting for the first divDone
    // SEQ_HOLD   | quotient captured, waiting for downstream to take it
    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_BUSY  = 2'd2,
        SEQ_HOLD  = 2'd3
    } fpuDivSeqState_t;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_DEPTH = 2;

    // Occupancy counter must hold the value DEPTH itself.
    function automatic int unsigned cnt_bits(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // A single-entry FIFO still needs a 1-bit pointer to stay legal.
    function automatic int unsigned ptr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fpu_div_sequencer_if.sv
// Bundle of the sequencer's upstream, downstream and divider-side signals.
//   slave  : seen from the sequencer (takes inA/inB, drives divIn*/divStart,
//            takes divOut/divDone, drives outValid/outResult/pending)
//   master : seen from the surrounding pipeline and divider
interface fpu_div_sequencer_if
    import fpu_div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned CW = cnt_bits(DEPTH);

    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [WIDTH-1:0] divIn1;
    logic [WIDTH-1:0] divIn2;
    logic             divStart;
    logic [WIDTH-1:0] divOut;
    logic             divDone;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outResult;
    logic [CW-1:0]    pending;

    modport slave (
        input  inValid, inA, inB, divOut, divDone, outReady,
        output inReady, divIn1, divIn2, divStart, outValid, outResult, pending
    );

    modport master (
        output inValid, inA, inB, divOut, divDone, outReady,
        input  inReady, divIn1, divIn2, divStart, outValid, outResult, pending
    );

endinterface

// File: rtl/fpu_div_sequencer_fifo.sv
// Operand FIFO for the divider sequencer: DEPTH entries of DATA_W bits.
// Ports:
//   clock, reset  : clock and asynchronous active-high reset
//   push_i/data_i : write one entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head, forced to zero while empty
//   count_o       : occupancy, 0..DEPTH
//   full_o/empty_o: occupancy flags
// DEPTH must be a power of two.
module fpu_div_fifo
    import fpu_div_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 2 * DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_o,
    output logic [cnt_bits(DEPTH)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = ptr_bits(DEPTH);
    localparam int unsigned CW = cnt_bits(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;

    // Zero while empty so the divider inputs never show a stale entry.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked until an entry is written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fpu_div_sequencer.sv
// Issue/retire front end wrapped around fpuDivider. Operand pairs are
// queued, issued one at a time, and the quotient is held on a valid/ready
// output so the pipeline never tracks divider latency.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset (shared with the divider)
//   bus   : slave side of fpu_div_sequencer_if (upstream inValid/inReady/
//           inA/inB, divider divIn1/divIn2/divStart/divOut/divDone,
//           downstream outValid/outReady/outResult, FIFO occupancy pending)
//
// state      | meaning
// SEQ_IDLE   | nothing in flight; go issue once the FIFO holds a pair
// SEQ_ISSUE  | one-cycle divStart with the FIFO head on divIn1/divIn2
// SEQ_BUSY   | wait for divDone; first one captures divOut and pops the head
// SEQ_HOLD   | outValid high until outReady, then issue next or go idle
module fpu_div_sequencer
    import fpu_div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    fpu_div_sequencer_if.slave bus
);
    localparam int unsigned CW = cnt_bits(DEPTH);

    fpuDivSeqState_t  state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;

    logic               fifo_push, fifo_pop;
    logic [2*WIDTH-1:0] fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty;

    // inReady looks only at occupancy; a same-cycle pop never frees a slot.
    assign fifo_push = bus.inValid && !fifo_full;
    // The head leaves only at retire, so divIn1/divIn2 hold through done.
    assign fifo_pop  = (state_q == SEQ_BUSY) && bus.divDone;

    fpu_div_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  ({bus.inA, bus.inB}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (!fifo_empty && !out_valid_q) begin
                    state_d = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                state_d = SEQ_BUSY;
            end
            SEQ_BUSY: begin
                if (bus.divDone) begin
                    out_result_d = bus.divOut;
                    out_valid_d  = 1'b1;
                    state_d      = SEQ_HOLD;
                end
            end
            SEQ_HOLD: begin
                if (bus.outReady) begin
                    out_valid_d = 1'b0;
                    // No pop can happen here, so only a push can add work.
                    state_d = (!fifo_empty || fifo_push) ? SEQ_ISSUE : SEQ_IDLE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= SEQ_IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
        end
    end

    assign bus.inReady   = !fifo_full;
    assign bus.divIn1    = fifo_head[2*WIDTH-1:WIDTH];
    assign bus.divIn2    = fifo_head[WIDTH-1:0];
    assign bus.divStart  = (state_q == SEQ_ISSUE);
    assign bus.outValid  = out_valid_q;
    assign bus.outResult = out_result_q;
    assign bus.pending   = fifo_count;

endmodule

// File: tb/tb_fpu_div_sequencer.sv
module tb_fpu_div_sequencer;
    logic clock;
    logic reset;

    fpu_div_sequencer_if #(.WIDTH(16), .DEPTH(2)) bus ();

    fpu_div_sequencer #(.WIDTH(16), .DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_q [$];

    // Stub divider knobs.
    int  lat      = 4;
    int  done_len = 1;
    bit  spur_req = 0;
    bit  rnd_rdy  = 0;
    int  stub_cnt = 0;
    int  hold_left = 0;
    logic [15:0] lat_a, lat_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Quotient the stub divider returns. Directed pairs use true fp16 quotients.
    function automatic logic [15:0] ref_quot(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h4600_4000: return 16'h4200;
            32'h3c00_4000: return 16'h3800;
            32'h4400_4000: return 16'h4000;
            32'h4800_4000: return 16'h4400;
            default:       return (a - b) ^ {b[7:0], a[15:8]} ^ 16'h5a5a;
        endcase
    endfunction

    // Stub divider: done rises lat+1 negedges after start is seen, for done_len cycles.
    always @(negedge clock) begin
        if (reset) begin
            stub_cnt    = 0;
            hold_left   = 0;
            bus.divDone = 1'b0;
            bus.divOut  = '0;
        end else begin
            if (stub_cnt > 0) begin
                chk("divIn1_stable", bus.divIn1, lat_a);
                chk("divIn2_stable", bus.divIn2, lat_b);
                stub_cnt--;
                if (stub_cnt == 0) begin
                    bus.divOut = ref_quot(lat_a, lat_b);
                    hold_left  = done_len;
                end
            end
            if (bus.divStart) begin
                chk("start_while_busy_or_valid", {stub_cnt != 0, bus.outValid}, 0);
                lat_a    = bus.divIn1;
                lat_b    = bus.divIn2;
                stub_cnt = lat + 1;
            end
            if (hold_left > 0) begin
                bus.divDone = 1'b1;
                hold_left--;
            end else if (spur_req) begin
                bus.divDone = 1'b1;
                bus.divOut  = 16'hdead;
                spur_req    = 0;
            end else begin
                bus.divDone = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every accepted result must match the oldest expected one.
    logic [15:0] last_res;
    bit          was_valid = 0;
    always @(negedge clock) begin
        if (reset) begin
            was_valid = 0;
        end else if (bus.outValid) begin
            if (was_valid) chk("outResult_hold", bus.outResult, last_res);
            last_res = bus.outResult;
            if (bus.outReady) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %h, nothing outstanding", bus.outResult);
                end else begin
                    chk("result_order", bus.outResult, exp_q.pop_front());
                end
                was_valid = 0;
            end else begin
                was_valid = 1;
            end
        end else begin
            was_valid = 0;
        end
    end

    always @(posedge clock) begin
        if (rnd_rdy) begin
            #1 bus.outReady = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        int waited = 0;
        @(negedge clock);
        bus.inValid = 1'b1;
        bus.inA     = a;
        bus.inB     = b;
        while (!bus.inReady && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.inReady) begin
            chk("push_accept_timeout", bus.inReady, 1);
            bus.inValid = 1'b0;
            return;
        end
        exp_q.push_back(ref_quot(a, b));
        @(posedge clock);
        #1 bus.inValid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || bus.outValid) && k < 1000) begin
            @(negedge clock);
            k++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_inReady",   bus.inReady,   1);
        chk("rst_divStart",  bus.divStart,  0);
        chk("rst_outValid",  bus.outValid,  0);
        chk("rst_outResult", bus.outResult, 0);
        chk("rst_divIn1",    bus.divIn1,    0);
        chk("rst_divIn2",    bus.divIn2,    0);
        chk("rst_pending",   bus.pending,   0);
    endtask

    initial begin
        int n;
        int m;
        logic [1:0] pend_before;

        reset        = 1'b1;
        bus.inValid  = 1'b0;
        bus.inA      = '0;
        bus.inB      = '0;
        bus.outReady = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_vals();
        @(posedge clock);
        #1 reset = 1'b0;

        // Single operation, cycle-exact latency.
        bus.outReady = 1'b1;
        push_pair(16'h4600, 16'h4000);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.divStart && n < 20);
        chk("issue_latency", n, 2);
        chk("issue_divIn1", bus.divIn1, 16'h4600);
        chk("issue_divIn2", bus.divIn2, 16'h4000);
        m = 0;
        do begin
            @(negedge clock);
            m++;
            if (m == 1) chk("start_pulse_width", bus.divStart, 0);
        end while (!bus.outValid && m < 40);
        chk("start_to_valid", m, 6);
        chk("single_result", bus.outResult, 16'h4200);
        @(negedge clock);
        chk("single_pending", bus.pending, 0);
        chk("single_valid_clear", bus.outValid, 0);

        // Fill the FIFO with downstream stalled, then stall in HOLD.
        @(posedge clock);
        #1 bus.outReady = 1'b0;
        push_pair(16'h3c00, 16'h4000);
        push_pair(16'h4400, 16'h4000);
        @(negedge clock);
        chk("full_pending", bus.pending, 2);
        chk("full_inReady", bus.inReady, 0);
        push_pair(16'h4800, 16'h4000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("stall_outValid", bus.outValid, 1);
            chk("stall_no_start", bus.divStart, 0);
        end
        chk("stall_result", bus.outResult, 16'h3800);
        @(posedge clock);
        #1 bus.outReady = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("release_issue", bus.divStart, 1);
        drain();

        // Spurious done in IDLE, then done held 3 cycles in BUSY.
        @(negedge clock);
        spur_req = 1;
        repeat (4) @(negedge clock);
        chk("spur_outValid", bus.outValid, 0);
        chk("spur_pending", bus.pending, 0);
        done_len = 3;
        push_pair(16'h4400, 16'h4000);
        push_pair(16'h4800, 16'h4000);
        drain();
        repeat (4) @(negedge clock);
        chk("long_done_pending", bus.pending, 0);
        chk("long_done_outValid", bus.outValid, 0);
        done_len = 1;

        // Reset while BUSY with two pairs queued.
        lat = 10;
        push_pair(16'h3c00, 16'h4000);
        push_pair(16'h4400, 16'h4000);
        n = 0;
        while (!bus.divStart && n < 20) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        chk("pre_reset_pending", bus.pending, 2);
        @(posedge clock);
        #3 reset = 1'b1;
        exp_q.delete();
        #1 chk_reset_vals();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        lat = 4;
        push_pair(16'h4600, 16'h4000);
        drain();

        // Push in the same cycle as the retiring done.
        push_pair(16'h3c00, 16'h4000);
        n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!bus.divDone && n < 40);
        chk("retire_pre_pending", bus.pending, 1);
        pend_before = bus.pending;
        bus.inValid = 1'b1;
        bus.inA     = 16'h4400;
        bus.inB     = 16'h4000;
        exp_q.push_back(ref_quot(16'h4400, 16'h4000));
        @(posedge clock);
        #1 bus.inValid = 1'b0;
        @(negedge clock);
        chk("retire_push_pending", bus.pending, pend_before);
        chk("retire_outValid", bus.outValid, 1);
        @(negedge clock);
        chk("hold_to_issue", bus.divStart, 1);
        drain();

        // Randomized traffic against the scoreboard.
        rnd_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            lat      = $urandom_range(1, 6);
            done_len = $urandom_range(1, 3);
            push_pair(16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        rnd_rdy = 0;
        @(posedge clock);
        #1 bus.outReady = 1'b1;
        drain();
        @(negedge clock);
        chk("final_pending", bus.pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got stuck, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
